// File: rtl/trigger_event_logger.sv
// Timestamps rising edges of trigger0/trigger1 against a shot-relative counter and
// buffers {flags, pulse_delay, timestamp} records in a first-word-fall-through FIFO.
module trigger_event_logger #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     trigger0,
  input  logic                     trigger1,
  input  logic [15:0]              pulse_delay,
  output logic [63:0]              m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow,
  output logic [15:0]              drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   FILL_ONE = (AW+1)'(1);
  localparam logic [AW:0]   FILL_MAX = (AW+1)'(DEPTH);

  logic                arm_q;
  logic                trig0_q, trig1_q;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic                overflow_q, overflow_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         fill_q, fill_d;
  logic [63:0]         m_data_q, m_data_d;
  logic [63:0]         mem_q [DEPTH];

  logic                start, t0_p0, t1_p0, event_v;
  logic                full, valid, pop, push, drop;
  logic [TS_WIDTH-1:0] ts_cur;
  logic [15:0]         drop_base;
  logic [63:0]         rec;

  always_comb begin
    start     = arm & ~arm_q;
    t0_p0     = trigger0 & ~trig0_q;
    t1_p0     = trigger1 & ~trig1_q;
    event_v   = arm & (t0_p0 | t1_p0);
    ts_cur    = start ? '0 : ts_q;
    valid     = (fill_q != '0);
    full      = (fill_q == FILL_MAX);
    pop       = valid & m_ready;
    push      = event_v & (~full | pop);
    drop      = event_v & full & ~pop;
    rec       = {t1_p0, t0_p0, 14'b0, pulse_delay, ts_cur};

    ts_d = ts_q;
    if (arm) ts_d = (&ts_cur) ? ts_cur : ts_cur + TS_WIDTH'(1);

    overflow_d = start ? 1'b0 : overflow_q;
    drop_base  = start ? '0 : drop_cnt_q;
    drop_cnt_d = drop_base;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_base != '1) drop_cnt_d = drop_base + 16'd1;
    end

    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    fill_d = fill_q;
    case ({push, pop})
      2'b10:   fill_d = fill_q + FILL_ONE;
      2'b01:   fill_d = fill_q - FILL_ONE;
      default: fill_d = fill_q;
    endcase

    // Head register is preloaded with whatever will sit at rd_ptr_d after this edge,
    // bypassing the memory when the new record becomes the head directly.
    m_data_d = m_data_q;
    if (pop && fill_q > FILL_ONE)
      m_data_d = mem_q[rd_ptr_q + PTR_ONE];
    else if (push && (fill_q == '0 || (pop && fill_q == FILL_ONE)))
      m_data_d = rec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arm_q      <= 1'b0;
      trig0_q    <= 1'b0;
      trig1_q    <= 1'b0;
      ts_q       <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      m_data_q   <= '0;
    end else begin
      arm_q      <= arm;
      trig0_q    <= trigger0;
      trig1_q    <= trigger1;
      ts_q       <= ts_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      m_data_q   <= m_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= rec;
  end

  assign m_data   = m_data_q;
  assign m_valid  = (fill_q != '0);
  assign fill     = fill_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_trigger_event_logger.sv
// Directed bench for trigger_event_logger: queue-based reference model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_trigger_event_logger;
  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0;
  logic        trigger0 = 1'b0;
  logic        trigger1 = 1'b0;
  logic [15:0] pulse_delay = 16'hFFFF;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [4:0]  fill;
  logic        overflow;
  logic [15:0] drop_cnt;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  trigger_event_logger #(.DEPTH(DEPTH), .TS_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .arm(arm), .trigger0(trigger0), .trigger1(trigger1),
    .pulse_delay(pulse_delay), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .fill(fill), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #4 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a queue of records plus shot state, advanced on each rising edge.
  logic [63:0] mq[$];
  logic [31:0] m_ts = 0, m_cur;
  bit          m_ovf = 0, m_arm_r = 0, m_t0d = 0, m_t1d = 0;
  bit          m_start, m_r0, m_r1, m_full, m_pop;
  logic [15:0] m_drop = 0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_ts = 0; m_ovf = 0; m_drop = 0; m_arm_r = 0; m_t0d = 0; m_t1d = 0;
    end else begin
      m_start = arm && !m_arm_r;
      m_cur   = m_start ? 32'd0 : m_ts;
      if (m_start) begin m_ovf = 0; m_drop = 0; end
      m_r0   = trigger0 && !m_t0d;
      m_r1   = trigger1 && !m_t1d;
      m_full = (mq.size() == DEPTH);
      m_pop  = (mq.size() != 0) && m_ready;
      if (m_pop) void'(mq.pop_front());
      if (arm && (m_r0 || m_r1)) begin
        if (!m_full || m_pop) mq.push_back({m_r1, m_r0, 14'b0, pulse_delay, m_cur});
        else begin
          m_ovf = 1;
          if (m_drop != 16'hFFFF) m_drop = m_drop + 1;
        end
      end
      if (arm) m_ts = (m_cur == 32'hFFFF_FFFF) ? m_cur : m_cur + 1;
      m_arm_r = arm; m_t0d = trigger0; m_t1d = trigger1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", {63'b0, m_valid}, {63'b0, mq.size() != 0});
      chk("fill", {59'b0, fill}, 64'(mq.size()));
      if (mq.size() != 0) chk("m_data", m_data, mq[0]);
      chk("overflow", {63'b0, overflow}, {63'b0, m_ovf});
      chk("drop_cnt", {48'b0, drop_cnt}, {48'b0, m_drop});
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic rearm();
    arm = 1'b0; step();
    arm = 1'b1;
  endtask

  initial begin
    // Reset
    rst = 1'b1; step();
    chk_en = 1'b1;
    chk("rst_fill", {59'b0, fill}, 64'd0);
    chk("rst_valid", {63'b0, m_valid}, 64'd0);
    chk("rst_data", m_data, 64'd0);
    chk("rst_drop", {48'b0, drop_cnt}, 64'd0);
    rst = 1'b0; step();

    // 1: two single-trigger records, m_ready held low
    arm = 1'b1;
    for (int c = 0; c <= 55; c++) begin
      trigger0 = (c == 10);
      trigger1 = (c == 50);
      pulse_delay = (c >= 50) ? 16'h0123 : 16'hFFFF;
      step();
      if (c == 9)  chk("t1_valid_before", {63'b0, m_valid}, 64'd0);
      if (c == 10) chk("t1_rec0", m_data, 64'h4000_FFFF_0000_000A);
      if (c == 50) chk("t1_fill2", {59'b0, fill}, 64'd2);
    end
    m_ready = 1'b1; step();
    chk("t1_rec1", m_data, 64'h8000_0123_0000_0032);
    step();
    chk("t1_empty", {63'b0, m_valid}, 64'd0);
    m_ready = 1'b0;

    // 2: simultaneous edges give one record with both flags
    rearm();
    for (int c = 0; c <= 9; c++) begin
      trigger0 = (c == 7);
      trigger1 = (c == 7);
      pulse_delay = 16'h0ABC;
      step();
    end
    chk("t2_both", m_data, 64'hC000_0ABC_0000_0007);
    chk("t2_fill1", {59'b0, fill}, 64'd1);
    m_ready = 1'b1; step(); m_ready = 1'b0;

    // 3: overflow with 20 pulses into a 16-deep FIFO
    rearm();
    for (int c = 0; c < 80; c++) begin
      trigger0 = (c % 4 == 0);
      pulse_delay = 16'h1000 + 16'(c);
      step();
    end
    chk("t3_fill16", {59'b0, fill}, 64'd16);
    chk("t3_drop4", {48'b0, drop_cnt}, 64'd4);
    chk("t3_ovf", {63'b0, overflow}, 64'd1);
    chk("t3_head", m_data, 64'h4000_1000_0000_0000);

    // 4: full FIFO, event and pop in the same cycle
    trigger0 = 1'b1; pulse_delay = 16'h1050; m_ready = 1'b1; step();
    trigger0 = 1'b0; m_ready = 1'b0;
    chk("t4_fill16", {59'b0, fill}, 64'd16);
    chk("t4_drop4", {48'b0, drop_cnt}, 64'd4);
    chk("t4_head", m_data, 64'h4000_1004_0000_0004);
    step();

    // 5: edges while disarmed are ignored; re-arm clears the shot stats
    arm = 1'b0;
    for (int c = 0; c < 8; c++) begin
      trigger0 = c[0];
      step();
    end
    trigger0 = 1'b0;
    chk("t5_fill", {59'b0, fill}, 64'd16);
    arm = 1'b1; step();
    chk("t5_ovf_clr", {63'b0, overflow}, 64'd0);
    chk("t5_drop_clr", {48'b0, drop_cnt}, 64'd0);
    m_ready = 1'b1;
    for (int c = 1; c < 24; c++) begin
      trigger0 = (c == 3);
      pulse_delay = 16'h2000;
      step();
    end
    chk("t5_drained", {59'b0, fill}, 64'd0);
    m_ready = 1'b0;

    // 6: reset mid-operation with an event in flight
    for (int c = 0; c < 20; c++) begin
      trigger0 = (c % 4 == 0);
      step();
    end
    chk("t6_fill5", {59'b0, fill}, 64'd5);
    rst = 1'b1; trigger0 = 1'b1; step();
    rst = 1'b0; trigger0 = 1'b0;
    chk("t6_fill0", {59'b0, fill}, 64'd0);
    chk("t6_valid0", {63'b0, m_valid}, 64'd0);
    chk("t6_ovf0", {63'b0, overflow}, 64'd0);
    for (int c = 0; c < 4; c++) begin
      trigger1 = (c == 2);
      step();
    end
    chk("t6_ts_restart", m_data, 64'h8000_2000_0000_0002);
    trigger1 = 1'b0; step();

    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
